// File: rtl/arb_burst_pkg.sv
// rtl/arb_burst_pkg.sv - shared types for the burst transfer block
package arb_burst_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int FIFO_DEPTH = 4;

    // Per-beat markers carried alongside data and source index.
    typedef struct packed {
        logic last;
        logic trunc;
    } beat_flags_t;

endpackage

// File: rtl/arb_burst_fifo.sv
// rtl/arb_burst_fifo.sv - 4-entry beat buffer; outputs hold the last popped beat when empty
module arb_burst_fifo
    import arb_burst_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_src,
    input  beat_flags_t       in_flags,
    output logic              full,
    output logic              valid,
    output logic [DATA_W-1:0] head_data,
    output logic [IDX_W-1:0]  head_src,
    output beat_flags_t       head_flags
);

    logic [DATA_W-1:0] mem_data  [FIFO_DEPTH];
    logic [IDX_W-1:0]  mem_src   [FIFO_DEPTH];
    beat_flags_t       mem_flags [FIFO_DEPTH];

    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;
    logic [DATA_W-1:0] held_data;
    logic [IDX_W-1:0]  held_src;
    beat_flags_t       held_flags;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == 3'd4);
    assign valid   = (count != 3'd0);
    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && valid;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_ptr]  <= in_data;
            mem_src[wr_ptr]   <= in_src;
            mem_flags[wr_ptr] <= in_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            held_data  <= '0;
            held_src   <= '0;
            held_flags <= '0;
        end else if (!clr_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            held_data  <= '0;
            held_src   <= '0;
            held_flags <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr     <= rd_ptr + 2'd1;
                held_data  <= mem_data[rd_ptr];
                held_src   <= mem_src[rd_ptr];
                held_flags <= mem_flags[rd_ptr];
            end
            count <= count + {2'b00, do_push} - {2'b00, do_pop};
        end
    end

    assign head_data  = valid ? mem_data[rd_ptr]  : held_data;
    assign head_src   = valid ? mem_src[rd_ptr]   : held_src;
    assign head_flags = valid ? mem_flags[rd_ptr] : held_flags;

endmodule

// File: rtl/arb_burst_xfer.sv
// rtl/arb_burst_xfer.sv - locks the arbiter for a burst and buffers accepted beats
module arb_burst_xfer
    import arb_burst_pkg::*;
#(
    parameter int N         = 4,
    parameter int IDX_W     = 2,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_n,
    input  logic                granted,
    input  logic [IDX_W-1:0]    grant_index,
    input  logic [N-1:0]        req_valid,
    input  logic [N*DATA_W-1:0] req_data,
    input  logic [N-1:0]        req_last,
    output logic                arb_enable,
    output logic [N-1:0]        lock,
    output logic [N-1:0]        ack,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [IDX_W-1:0]    out_src,
    output logic                out_last,
    output logic                out_trunc
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  sel, sel_nx;
    logic [CNT_W-1:0]  beat_cnt, cnt_nx;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              live;
    logic              at_limit;
    logic              full;
    beat_flags_t       push_flags;
    beat_flags_t       head_flags;

    // No beat is acknowledged while either clear is asserted.
    assign live     = rst_n && init_n;
    assign at_limit = (state == BURST) && (beat_cnt == CNT_W'(MAX_BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            beat_cnt <= '0;
        end else if (!init_n) begin
            state    <= IDLE;
            sel      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            beat_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        sel_nx     = sel;
        cnt_nx     = beat_cnt;
        idx        = sel;
        accept     = 1'b0;
        push_flags = '0;
        case (state)
            IDLE: begin
                idx    = grant_index;
                accept = live && granted && !full && req_valid[grant_index];
                if (accept) begin
                    if (req_last[grant_index]) begin
                        push_flags.last = 1'b1;
                    end else begin
                        state_nx = BURST;
                        sel_nx   = grant_index;
                        cnt_nx   = CNT_W'(1);
                    end
                end
            end
            BURST: begin
                accept = live && !full && req_valid[sel];
                if (accept) begin
                    if (req_last[sel] || at_limit) begin
                        push_flags.last  = 1'b1;
                        push_flags.trunc = !req_last[sel];
                        state_nx         = IDLE;
                        cnt_nx           = '0;
                    end else begin
                        cnt_nx = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        ack  = '0;
        lock = '0;
        if (accept) begin
            ack[idx] = 1'b1;
        end
        if (state == BURST) begin
            lock[sel] = 1'b1;
        end
    end

    assign arb_enable = !full;

    arb_burst_fifo #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_n      (init_n),
        .push       (accept),
        .pop        (out_ready),
        .in_data    (req_data[idx*DATA_W +: DATA_W]),
        .in_src     (idx),
        .in_flags   (push_flags),
        .full       (full),
        .valid      (out_valid),
        .head_data  (out_data),
        .head_src   (out_src),
        .head_flags (head_flags)
    );

    assign out_last  = head_flags.last;
    assign out_trunc = head_flags.trunc;

endmodule

// File: tb/tb_arb_burst_xfer.sv
// tb/tb_arb_burst_xfer.sv - randomized bench against a queue-based reference model
module tb_arb_burst_xfer;

    localparam int N         = 4;
    localparam int IDX_W     = 2;
    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                init_n;
    logic                granted;
    logic [IDX_W-1:0]    grant_index;
    logic [N-1:0]        req_valid;
    logic [N*DATA_W-1:0] req_data;
    logic [N-1:0]        req_last;
    logic                arb_enable;
    logic [N-1:0]        lock;
    logic [N-1:0]        ack;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [IDX_W-1:0]    out_src;
    logic                out_last;
    logic                out_trunc;

    arb_burst_xfer #(
        .N(N), .IDX_W(IDX_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_n(init_n), .granted(granted),
        .grant_index(grant_index), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .arb_enable(arb_enable), .lock(lock), .ack(ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_last(out_last), .out_trunc(out_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                src;
        bit                last;
        bit                trunc;
    } beat_t;

    beat_t q[$];
    beat_t last_pop;
    int    owner;
    int    beats;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    ack_total = 0;
    int    trunc_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        owner = -1;
        beats = 0;
        last_pop = '{data: '0, src: 0, last: 1'b0, trunc: 1'b0};
    endtask

    task automatic check_outputs();
        chk("arb_enable", 64'(arb_enable), 64'(q.size() < 4));
        chk("lock", 64'(lock), (owner < 0) ? 64'd0 : (64'd1 << owner));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].data));
            chk("out_src", 64'(out_src), 64'(q[0].src));
            chk("out_flags", {62'd0, out_last, out_trunc}, {62'd0, q[0].last, q[0].trunc});
        end else begin
            chk("held_data", 64'(out_data), 64'(last_pop.data));
            chk("held_flags", {62'd0, out_last, out_trunc}, {62'd0, last_pop.last, last_pop.trunc});
        end
    endtask

    // Checks one cycle with the inputs already driven, then clocks the model.
    task automatic step();
        bit    acc;
        int    idx;
        bit    lst;
        beat_t b;
        #1;
        check_outputs();
        acc = 1'b0;
        if (owner < 0) begin
            idx = int'(grant_index);
            acc = rst_n && init_n && granted && req_valid[idx] && q.size() < 4;
        end else begin
            idx = owner;
            acc = rst_n && init_n && req_valid[idx] && q.size() < 4;
        end
        chk("ack", 64'(ack), acc ? (64'd1 << idx) : 64'd0);
        @(posedge clk);
        if (!init_n) begin
            model_clear();
        end else begin
            if (q.size() > 0 && out_ready) begin
                last_pop = q.pop_front();
            end
            if (acc) begin
                ack_total++;
                lst = req_last[idx];
                b = '{data: req_data[idx*DATA_W +: DATA_W], src: idx, last: lst, trunc: 1'b0};
                if (owner < 0) begin
                    if (!lst) begin
                        owner = idx;
                        beats = 1;
                    end
                end else begin
                    beats++;
                    if (lst) begin
                        owner = -1;
                    end else if (beats == MAX_BEATS) begin
                        b.last  = 1'b1;
                        b.trunc = 1'b1;
                        owner   = -1;
                        trunc_seen++;
                    end
                end
                q.push_back(b);
            end
        end
        #1;
    endtask

    task automatic drive_random(input int cyc);
        granted     = ($urandom_range(0, 3) != 0);
        grant_index = IDX_W'($urandom_range(0, N - 1));
        for (int i = 0; i < N; i++) begin
            req_valid[i] = ($urandom_range(0, 3) != 0);
            req_last[i]  = ($urandom_range(0, 5) == 0);
            req_data[i*DATA_W +: DATA_W] = $urandom;
        end
        // Alternate stretches of free flow, heavy stall and long bursts.
        case ((cyc / 40) % 3)
            0: out_ready = ($urandom_range(0, 3) != 0);
            1: out_ready = ($urandom_range(0, 5) == 0);
            default: begin
                out_ready = 1'b1;
                req_last  = '0;
            end
        endcase
        init_n = ($urandom_range(0, 149) != 0);
    endtask

    task automatic drive_idle();
        granted     = 1'b0;
        grant_index = '0;
        req_valid   = '0;
        req_last    = '0;
        req_data    = '0;
        out_ready   = 1'b0;
        init_n      = 1'b1;
    endtask

    initial begin
        model_clear();
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lock", 64'(lock), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", {out_data, out_src, out_last, out_trunc}, 64'd0);
        chk("rst_arb_enable", 64'(arb_enable), 64'd1);
        rst_n = 1'b1;
        step();

        // Single beat from requester 2.
        granted = 1'b1; grant_index = 2'd2; req_valid = 4'b0100; req_last = 4'b0100;
        req_data[2*DATA_W +: DATA_W] = 32'hCAFE_0002; out_ready = 1'b1;
        #1;
        chk("single_ack", 64'(ack), 64'h4);
        step();
        drive_idle(); out_ready = 1'b1;
        chk("single_src", {62'd0, out_src}, 64'd2);
        chk("single_last", 64'(out_last), 64'd1);
        step();

        for (int c = 0; c < 2400; c++) begin
            drive_random(c);
            step();
        end

        // Mid-burst asynchronous reset.
        drive_idle();
        init_n = 1'b0;
        step();
        init_n = 1'b1; granted = 1'b1; grant_index = 2'd1; req_valid = 4'b0010;
        req_data[1*DATA_W +: DATA_W] = 32'h1111_0001;
        step();
        chk("burst_lock", 64'(lock), 64'h2);
        req_data[1*DATA_W +: DATA_W] = 32'h1111_0002;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_lock", 64'(lock), 64'd0);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_ack", 64'(ack), 64'd0);
        model_clear();
        drive_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_rel_enable", 64'(arb_enable), 64'd1);
        for (int c = 0; c < 200; c++) begin
            drive_random(c);
            step();
        end

        chk("saw_truncation", 64'(trunc_seen > 0), 64'd1);
        chk("saw_traffic", 64'(ack_total > 100), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
